// File: rtl/hsstlp_rst_pkg.sv
// Shared definitions for the HSSTLP lane reset sequencer: state encodings,
// default timing parameters and the per-state output map.
package hsstlp_rst_pkg;

    typedef enum logic [2:0] {
        RST_PLL   = 3'd0,
        WAIT_LOCK = 3'd1,
        RLS_PD    = 3'd2,
        RLS_LANE  = 3'd3,
        WAIT_CDR  = 3'd4,
        RLS_PCS   = 3'd5,
        DONE      = 3'd6
    } state_e;

    localparam int unsigned CNT_WIDTH_DEF    = 16;
    localparam logic [15:0] PLL_RST_CNT_DEF  = 16'd640;
    localparam logic [15:0] STEP_CNT_DEF     = 16'd32;
    localparam logic [15:0] LOCK_TIMEOUT_DEF = 16'hFFFF;

    typedef struct packed {
        logic pll_rst;
        logic lane_pd;
        logic lane_rst;
        logic pcs_rst;
        logic ready;
    } rst_out_t;

    // Moore output map; anything unexpected looks like RST_PLL.
    function automatic rst_out_t state_outputs(input state_e s);
        rst_out_t o;
        case (s)
            WAIT_LOCK: o = 5'b01110;
            RLS_PD:    o = 5'b00110;
            RLS_LANE:  o = 5'b00010;
            WAIT_CDR:  o = 5'b00010;
            RLS_PCS:   o = 5'b00000;
            DONE:      o = 5'b00001;
            default:   o = 5'b11110;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/hsstlp_lane_rst_seq.sv
// Lane reset sequencer: walks PLL reset, powerdown, PMA reset and PCS reset
// release against PLL/CDR lock, with lock-wait timeouts and loss recovery.
module hsstlp_lane_rst_seq
    import hsstlp_rst_pkg::*;
#(
    parameter int                   CNT_WIDTH    = CNT_WIDTH_DEF,
    parameter logic [CNT_WIDTH-1:0] PLL_RST_CNT  = CNT_WIDTH'(PLL_RST_CNT_DEF),
    parameter logic [CNT_WIDTH-1:0] STEP_CNT     = CNT_WIDTH'(STEP_CNT_DEF),
    parameter logic [CNT_WIDTH-1:0] LOCK_TIMEOUT = CNT_WIDTH'(LOCK_TIMEOUT_DEF)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       soft_rst,
    input  logic       pll_lock_deb,
    input  logic       cdr_lock_deb,
    output logic       pll_rst,
    output logic       lane_pd,
    output logic       lane_rst,
    output logic       pcs_rst,
    output logic       ready,
    output logic [2:0] fsm_state,
    output logic [3:0] timeout_cnt
);

    localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] PLL_LAST  = PLL_RST_CNT - ONE;
    localparam logic [CNT_WIDTH-1:0] STEP_LAST = STEP_CNT - ONE;

    state_e               state_q, state_nx;
    logic [CNT_WIDTH-1:0] timer_q;
    logic [3:0]           tmo_cnt_q;
    logic                 tmo_hit;
    rst_out_t             out_q;

    function automatic logic [CNT_WIDTH-1:0] timer_sat_inc(input logic [CNT_WIDTH-1:0] t);
        return (t == '1) ? t : t + ONE;
    endfunction

    function automatic logic [3:0] tmo_sat_inc(input logic [3:0] c);
        return (c == 4'd15) ? c : c + 4'd1;
    endfunction

    // Loss and restart conditions pre-empt the per-state advance rules.
    always_comb begin
        state_nx = state_q;
        tmo_hit  = 1'b0;
        if (soft_rst) begin
            state_nx = RST_PLL;
        end else if (!pll_lock_deb && state_q != RST_PLL && state_q != WAIT_LOCK) begin
            state_nx = RST_PLL;
        end else if (!cdr_lock_deb && (state_q == RLS_PCS || state_q == DONE)) begin
            state_nx = WAIT_CDR;
        end else begin
            case (state_q)
                RST_PLL:   if (timer_q == PLL_LAST) state_nx = WAIT_LOCK;
                WAIT_LOCK: begin
                    if (pll_lock_deb) begin
                        state_nx = RLS_PD;
                    end else if (timer_q == LOCK_TIMEOUT) begin
                        state_nx = RST_PLL;
                        tmo_hit  = 1'b1;
                    end
                end
                RLS_PD:    if (timer_q == STEP_LAST) state_nx = RLS_LANE;
                RLS_LANE:  if (timer_q == STEP_LAST) state_nx = WAIT_CDR;
                WAIT_CDR: begin
                    if (cdr_lock_deb) begin
                        state_nx = RLS_PCS;
                    end else if (timer_q == LOCK_TIMEOUT) begin
                        state_nx = RLS_PD;
                        tmo_hit  = 1'b1;
                    end
                end
                RLS_PCS:   if (timer_q == STEP_LAST) state_nx = DONE;
                DONE:      state_nx = DONE;
                default:   state_nx = RST_PLL;
            endcase
        end
    end

    // Outputs are registered from the next state so they move with fsm_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RST_PLL;
            timer_q   <= '0;
            tmo_cnt_q <= 4'd0;
            out_q     <= state_outputs(RST_PLL);
        end else begin
            state_q <= state_nx;
            timer_q <= (state_nx != state_q || soft_rst) ? '0 : timer_sat_inc(timer_q);
            if (tmo_hit) tmo_cnt_q <= tmo_sat_inc(tmo_cnt_q);
            out_q   <= state_outputs(state_nx);
        end
    end

    assign pll_rst     = out_q.pll_rst;
    assign lane_pd     = out_q.lane_pd;
    assign lane_rst    = out_q.lane_rst;
    assign pcs_rst     = out_q.pcs_rst;
    assign ready       = out_q.ready;
    assign fsm_state   = state_q;
    assign timeout_cnt = tmo_cnt_q;

endmodule

// File: tb/tb_hsstlp_lane_rst_seq.sv
// Bench for hsstlp_lane_rst_seq: directed scenarios plus randomized lock and
// restart stimulus, checked each cycle against a dwell-time reference model.
module tb_hsstlp_lane_rst_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       soft_rst;
    logic       pll_lock_deb;
    logic       cdr_lock_deb;
    logic       pll_rst, lane_pd, lane_rst, pcs_rst, ready;
    logic [2:0] fsm_state;
    logic [3:0] timeout_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: phase index, cycles spent in it, and timeout tally.
    int m_ph, m_age, m_tcnt;
    logic [4:0] out_tbl [7] = '{5'b11110, 5'b01110, 5'b00110, 5'b00010,
                                5'b00010, 5'b00000, 5'b00001};
    int dwell [7] = '{8, 0, 4, 4, 0, 4, 0};
    int after [7] = '{1, 0, 3, 4, 0, 6, 0};

    always #5 clk = ~clk;

    hsstlp_lane_rst_seq #(
        .CNT_WIDTH   (16),
        .PLL_RST_CNT (16'd8),
        .STEP_CNT    (16'd4),
        .LOCK_TIMEOUT(16'd20)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .soft_rst    (soft_rst),
        .pll_lock_deb(pll_lock_deb),
        .cdr_lock_deb(cdr_lock_deb),
        .pll_rst     (pll_rst),
        .lane_pd     (lane_pd),
        .lane_rst    (lane_rst),
        .pcs_rst     (pcs_rst),
        .ready       (ready),
        .fsm_state   (fsm_state),
        .timeout_cnt (timeout_cnt)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_age = 0; m_tcnt = 0;
    endtask

    task automatic model_go(input int ph);
        m_ph = ph; m_age = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        if (soft_rst) model_go(0);
        else if (!pll_lock_deb && m_ph >= 2) model_go(0);
        else if (!cdr_lock_deb && m_ph >= 5) model_go(4);
        else if (m_ph == 1 || m_ph == 4) begin
            if ((m_ph == 1 && pll_lock_deb) || (m_ph == 4 && cdr_lock_deb))
                model_go(m_ph + 1);
            else if (m_age == 20) begin
                if (m_tcnt < 15) m_tcnt++;
                model_go(m_ph == 1 ? 0 : 2);
            end else m_age++;
        end else if (m_ph == 6) m_age++;
        else if (m_age == dwell[m_ph] - 1) model_go(after[m_ph]);
        else m_age++;
    endtask

    task automatic check_model();
        chk("fsm_state", {5'd0, fsm_state}, 8'(m_ph));
        chk("outputs", {3'd0, pll_rst, lane_pd, lane_rst, pcs_rst, ready}, {3'd0, out_tbl[m_ph]});
        chk("timeout_cnt", {4'd0, timeout_cnt}, 8'(m_tcnt));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic run_until_state(input logic [2:0] target, input int max_cycles);
        int n = 0;
        while (fsm_state !== target && n < max_cycles) begin
            step();
            n++;
        end
        chk("reach_state", {5'd0, fsm_state}, {5'd0, target});
    endtask

    initial begin
        int e_pll, e_pd, e_lane, e_cdr, e_pcs, e_rdy, n;
        logic [3:0] saved_tcnt;

        rst_n = 1'b0; soft_rst = 1'b0; pll_lock_deb = 1'b1; cdr_lock_deb = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model();
        chk("reset_outputs", {3'd0, pll_rst, lane_pd, lane_rst, pcs_rst, ready}, 8'h1E);

        // Nominal bring-up with both locks held.
        rst_n = 1'b1;
        e_pll = -1; e_pd = -1; e_lane = -1; e_cdr = -1; e_pcs = -1; e_rdy = -1;
        for (int e = 1; e <= 26; e++) begin
            step();
            if (e_pll < 0 && !pll_rst) e_pll = e;
            if (e_pd < 0 && !lane_pd) e_pd = e;
            if (e_lane < 0 && !lane_rst) e_lane = e;
            if (e_cdr < 0 && fsm_state == 3'd4) e_cdr = e;
            if (e_pcs < 0 && !pcs_rst) e_pcs = e;
            if (e_rdy < 0 && ready) e_rdy = e;
        end
        chk("edge_pll_rst_fall", 8'(e_pll), 8'd8);
        chk("edge_lane_pd_fall", 8'(e_pd), 8'd9);
        chk("edge_lane_rst_fall", 8'(e_lane), 8'd13);
        chk("edge_wait_cdr", 8'(e_cdr), 8'd17);
        chk("edge_pcs_rst_fall", 8'(e_pcs), 8'd18);
        chk("edge_ready_rise", 8'(e_rdy), 8'd22);

        // PLL lock loss pulse in DONE.
        pll_lock_deb = 1'b0;
        step();
        pll_lock_deb = 1'b1;
        chk("pll_loss_outputs", {3'd0, pll_rst, lane_pd, lane_rst, pcs_rst, ready}, 8'h1E);
        chk("pll_loss_state", {5'd0, fsm_state}, 8'd0);
        run_until_state(3'd6, 40);

        // CDR lock loss for three cycles in DONE.
        cdr_lock_deb = 1'b0;
        step();
        chk("cdr_loss_pcs_rst", {7'd0, pcs_rst}, 8'd1);
        chk("cdr_loss_ready", {7'd0, ready}, 8'd0);
        chk("cdr_loss_state", {5'd0, fsm_state}, 8'd4);
        step();
        step();
        cdr_lock_deb = 1'b1;
        n = 0;
        while (!ready && n < 20) begin
            step();
            n++;
        end
        chk("cdr_restore_latency", 8'(n), 8'd5);

        // soft_rst and CDR loss together: restart wins.
        saved_tcnt = timeout_cnt;
        soft_rst = 1'b1; cdr_lock_deb = 1'b0;
        step();
        soft_rst = 1'b0;
        chk("simul_state", {5'd0, fsm_state}, 8'd0);
        chk("simul_tcnt", {4'd0, timeout_cnt}, {4'd0, saved_tcnt});

        // CDR never locks: repeated WAIT_CDR timeouts back to RLS_PD.
        for (int i = 0; i < 80; i++) step();
        chk("cdr_timeouts_seen", 8'(timeout_cnt >= 4'd2), 8'd1);
        cdr_lock_deb = 1'b1;

        // Asynchronous reset in RLS_LANE, observed before the next edge.
        soft_rst = 1'b1;
        step();
        soft_rst = 1'b0;
        run_until_state(3'd3, 30);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_outputs", {3'd0, pll_rst, lane_pd, lane_rst, pcs_rst, ready}, 8'h1E);
        chk("async_rst_state", {5'd0, fsm_state}, 8'd0);
        chk("async_rst_tcnt", {4'd0, timeout_cnt}, 8'd0);
        @(posedge clk);
        #1;
        check_model();

        // PLL never locks: WAIT_LOCK dwell and saturation of the tally.
        pll_lock_deb = 1'b0;
        rst_n = 1'b1;
        run_until_state(3'd1, 20);
        n = 1;
        while (fsm_state == 3'd1 && n < 40) begin
            step();
            if (fsm_state == 3'd1) n++;
        end
        chk("wait_lock_len", 8'(n), 8'd21);
        chk("first_timeout", {4'd0, timeout_cnt}, 8'd1);
        for (int i = 0; i < 16 * 29 + 10; i++) step();
        chk("timeout_saturated", {4'd0, timeout_cnt}, 8'd15);

        // Randomized lock and restart activity.
        pll_lock_deb = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            pll_lock_deb = ($urandom_range(0, 39) != 0);
            cdr_lock_deb = ($urandom_range(0, 11) != 0);
            soft_rst     = ($urandom_range(0, 149) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
